// File: rtl/mips_cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_pkg
// Brief    : Shared types, lane masks and request decode helpers for the bus master.
// Revision : 1.0
// ============================================================================
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUS   = 2'b01,
        RDATA = 2'b10,
        RESP  = 2'b11
    } bus_state_t;

    localparam logic [3:0] LANES_NONE = 4'b0000;
    localparam logic [3:0] LANE_B0    = 4'b0001;
    localparam logic [3:0] LANES_LO   = 4'b0011;
    localparam logic [3:0] LANES_HI   = 4'b1100;
    localparam logic [3:0] LANES_ALL  = 4'b1111;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic access_size_t decode_size(input logic [1:0] size);
        case (size)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_if
// Brief    : Core request/response channel plus Avalon-style memory port.
// Revision : 1.0
// ============================================================================
interface mips_cpu_bus_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );

endinterface
`default_nettype wire

// File: rtl/mips_cpu_bus_lane_steer.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_lane_steer
// Brief    : Byte-lane enables, store-data replication and load extract/extend.
// Revision : 1.0
// ============================================================================
module mips_cpu_bus_lane_steer
    import mips_cpu_bus_pkg::*;
(
    input  access_size_t wr_size_i,
    input  logic [1:0]   wr_off_i,
    input  logic [31:0]  wr_data_i,
    output logic [3:0]   be_o,
    output logic [31:0]  wdata_o,
    input  access_size_t rd_size_i,
    input  logic [1:0]   rd_off_i,
    input  logic         rd_signed_i,
    input  logic [31:0]  rd_raw_i,
    output logic [31:0]  rd_data_o
);

    logic [31:0] w_shifted;

    always_comb begin
        be_o    = LANES_ALL;
        wdata_o = wr_data_i;
        case (wr_size_i)
            SZ_BYTE: begin
                be_o    = LANE_B0 << wr_off_i;
                wdata_o = {4{wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = wr_off_i[1] ? LANES_HI : LANES_LO;
                wdata_o = {2{wr_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Half accesses are only ever at offset 0 or 2, so one byte-granular shift serves both sizes.
    assign w_shifted = rd_raw_i >> {rd_off_i, 3'b000};

    always_comb begin
        rd_data_o = rd_raw_i;
        case (rd_size_i)
            SZ_BYTE: rd_data_o = {{24{rd_signed_i & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: rd_data_o = {{16{rd_signed_i & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_master
// Brief    : Single-outstanding bus initiator between the core and the memory port.
// Revision : 1.0
// ============================================================================
module mips_cpu_bus_master
    import mips_cpu_bus_pkg::*;
#(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    mips_cpu_bus_if.master    bus
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    bus_state_t   state_q;
    logic         read_q;
    logic         write_q;
    logic [3:0]   be_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    logic         rsp_valid_q;
    logic         rsp_err_q;
    logic [31:0]  rsp_rdata_q;
    access_size_t size_q;
    logic [1:0]   off_q;
    logic         signed_q;
    logic         err_q;
    logic [31:0]  rdata_q;
    logic [CW-1:0] wd_cnt_q;

    access_size_t w_size;
    logic         w_misaligned;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_rd_fmt;
    logic         w_wd_expire;

    assign w_size       = decode_size(bus.req_size);
    assign w_misaligned = is_misaligned(w_size, bus.req_addr[1:0]);
    assign w_wd_expire  = (WAIT_LIMIT != 0) && (wd_cnt_q == CW'(WAIT_LIMIT - 1));

    // Store side steers from the live request at accept; load side uses the latched fields.
    mips_cpu_bus_lane_steer u_lane_steer (
        .wr_size_i   (w_size),
        .wr_off_i    (bus.req_addr[1:0]),
        .wr_data_i   (bus.req_wdata),
        .be_o        (w_be),
        .wdata_o     (w_wdata),
        .rd_size_i   (size_q),
        .rd_off_i    (off_q),
        .rd_signed_i (signed_q),
        .rd_raw_i    (bus.readdata),
        .rd_data_o   (w_rd_fmt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            be_q        <= LANES_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            wd_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q   <= w_size;
                        off_q    <= bus.req_addr[1:0];
                        signed_q <= bus.req_signed;
                        rdata_q  <= '0;
                        wd_cnt_q <= '0;
                        if (w_misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            addr_q  <= {bus.req_addr[31:2], 2'b00};
                            be_q    <= w_be;
                            wdata_q <= bus.req_write ? w_wdata : 32'h0;
                            read_q  <= ~bus.req_write;
                            write_q <= bus.req_write;
                            state_q <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!bus.waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state_q <= read_q ? RDATA : RESP;
                    end else if (w_wd_expire) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CW'(1);
                    end
                end
                RDATA: begin
                    rdata_q <= w_rd_fmt;
                    state_q <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= err_q ? 32'h0 : rdata_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.address    = addr_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus_master
// Brief    : Directed self-checking bench for the bus master.
// Revision : 1.0
// ============================================================================
module tb_mips_cpu_bus_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_if bif ();
    mips_cpu_bus_if wif ();

    mips_cpu_bus_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    mips_cpu_bus_master #(.WAIT_LIMIT(4)) dut_wd (
        .clk   (clk),
        .reset (reset),
        .bus   (wif)
    );

    task automatic idle_inputs();
        bif.req_valid = 0; bif.req_write = 0; bif.req_size = 2'b10; bif.req_signed = 0;
        bif.req_addr = 32'h0; bif.req_wdata = 32'h0; bif.waitrequest = 0; bif.readdata = 32'h0;
        wif.req_valid = 0; wif.req_write = 0; wif.req_size = 2'b10; wif.req_signed = 0;
        wif.req_addr = 32'h0; wif.req_wdata = 32'h0; wif.waitrequest = 0; wif.readdata = 32'h0;
    endtask

    // Drives one load with zero wait states; readdata carries word only in the cycle after the bus accept.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] word,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic [3:0] be_s, output logic [31:0] addr_s);
        logic acc;
        logic seen;
        rd = 32'h0; er = 1'b0; lat = -1; be_s = 4'h0; addr_s = 32'h0; seen = 1'b0;
        bif.req_valid = 1; bif.req_write = 0; bif.req_size = sz; bif.req_signed = sg;
        bif.req_addr = a; bif.req_wdata = 32'h0; bif.waitrequest = 0; bif.readdata = 32'hDEADBEEF;
        for (int i = 0; i < 12; i++) begin
            acc = bif.read && !bif.waitrequest;
            @(posedge clk); #1;
            bif.req_valid = 0;
            bif.readdata = acc ? word : 32'hDEADBEEF;
            if (bif.read && !seen) begin seen = 1'b1; be_s = bif.byteenable; addr_s = bif.address; end
            if (bif.rsp_valid) begin rd = bif.rsp_rdata; er = bif.rsp_err; lat = i; break; end
        end
    endtask

    task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                             output logic [3:0] be_s, output logic [31:0] addr_s, output logic [31:0] wd_s,
                             output logic rd_seen, output logic [31:0] rd, output logic er, output int lat);
        logic seen;
        be_s = 4'h0; addr_s = 32'h0; wd_s = 32'h0; rd_seen = 1'b0; rd = 32'hFFFFFFFF; er = 1'b1; lat = -1;
        seen = 1'b0;
        bif.req_valid = 1; bif.req_write = 1; bif.req_size = sz; bif.req_signed = 0;
        bif.req_addr = a; bif.req_wdata = d; bif.waitrequest = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bif.req_valid = 0;
            if (bif.read) rd_seen = 1'b1;
            if (bif.write && !seen) begin
                seen = 1'b1; be_s = bif.byteenable; addr_s = bif.address; wd_s = bif.writedata;
            end
            if (bif.rsp_valid) begin rd = bif.rsp_rdata; er = bif.rsp_err; lat = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bif.read !== 1'b0)       begin bad++; $display("FAIL reset_read got=%b want=0", bif.read); end
        total++; if (bif.write !== 1'b0)      begin bad++; $display("FAIL reset_write got=%b want=0", bif.write); end
        total++; if (bif.byteenable !== 4'h0) begin bad++; $display("FAIL reset_be got=%h want=0", bif.byteenable); end
        total++; if (bif.address !== 32'h0)   begin bad++; $display("FAIL reset_addr got=%h want=0", bif.address); end
        total++; if (bif.writedata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bif.writedata); end
        total++; if (bif.rsp_valid !== 1'b0 || bif.rsp_err !== 1'b0)
            begin bad++; $display("FAIL reset_rsp got=%b%b want=00", bif.rsp_valid, bif.rsp_err); end
        total++; if (bif.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bif.rsp_rdata); end
        reset = 0;
        @(posedge clk); #1;
        total++; if (bif.req_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b want=1", bif.req_ready); end
    endtask

    task automatic test_load_word();
        logic [31:0] rd, ad; logic er; int lat; logic [3:0] be;
        run_load(32'h100, 2'b10, 1'b0, 32'h12345678, rd, er, lat, be, ad);
        total++; if (lat !== 3)            begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
        total++; if (be !== 4'b1111)       begin bad++; $display("FAIL lw_be got=%b want=1111", be); end
        total++; if (ad !== 32'h100)       begin bad++; $display("FAIL lw_addr got=%h want=00000100", ad); end
        total++; if (rd !== 32'h12345678)  begin bad++; $display("FAIL lw_rdata got=%h want=12345678", rd); end
        total++; if (er !== 1'b0)          begin bad++; $display("FAIL lw_err got=%b want=0", er); end
    endtask

    task automatic test_subword_loads();
        logic [31:0] rd, ad; logic er; int lat; logic [3:0] be;
        run_load(32'h103, 2'b00, 1'b1, 32'h80112233, rd, er, lat, be, ad);
        total++; if (be !== 4'b1000)       begin bad++; $display("FAIL lb_be got=%b want=1000", be); end
        total++; if (ad !== 32'h100)       begin bad++; $display("FAIL lb_addr got=%h want=00000100", ad); end
        total++; if (rd !== 32'hFFFFFF80)  begin bad++; $display("FAIL lb_signed got=%h want=ffffff80", rd); end
        run_load(32'h103, 2'b00, 1'b0, 32'h80112233, rd, er, lat, be, ad);
        total++; if (rd !== 32'h00000080)  begin bad++; $display("FAIL lbu got=%h want=00000080", rd); end
        run_load(32'h101, 2'b00, 1'b1, 32'h1234F00D, rd, er, lat, be, ad);
        total++; if (be !== 4'b0010 || rd !== 32'hFFFFFFF0)
            begin bad++; $display("FAIL lb_lane1 got=%b/%h want=0010/fffffff0", be, rd); end
        run_load(32'h102, 2'b01, 1'b1, 32'h80011234, rd, er, lat, be, ad);
        total++; if (be !== 4'b1100 || rd !== 32'hFFFF8001)
            begin bad++; $display("FAIL lh_signed got=%b/%h want=1100/ffff8001", be, rd); end
        run_load(32'h100, 2'b01, 1'b0, 32'h1234F00D, rd, er, lat, be, ad);
        total++; if (be !== 4'b0011 || rd !== 32'h0000F00D)
            begin bad++; $display("FAIL lhu got=%b/%h want=0011/0000f00d", be, rd); end
        run_load(32'h204, 2'b11, 1'b1, 32'h89ABCDEF, rd, er, lat, be, ad);
        total++; if (be !== 4'b1111 || rd !== 32'h89ABCDEF || er !== 1'b0)
            begin bad++; $display("FAIL size11_word got=%b/%h/%b want=1111/89abcdef/0", be, rd, er); end
    endtask

    task automatic test_stores();
        logic [3:0] be; logic [31:0] ad, wd, rd; logic rs, er; int lat;
        run_store(32'h202, 2'b01, 32'h0000BEEF, be, ad, wd, rs, rd, er, lat);
        total++; if (ad !== 32'h200)       begin bad++; $display("FAIL sh_addr got=%h want=00000200", ad); end
        total++; if (be !== 4'b1100)       begin bad++; $display("FAIL sh_be got=%b want=1100", be); end
        total++; if (wd !== 32'hBEEFBEEF)  begin bad++; $display("FAIL sh_wdata got=%h want=beefbeef", wd); end
        total++; if (lat !== 2)            begin bad++; $display("FAIL sh_latency got=%0d want=2", lat); end
        total++; if (er !== 1'b0 || rd !== 32'h0 || rs !== 1'b0)
            begin bad++; $display("FAIL sh_rsp got=err%b/%h/rd%b want=err0/0/rd0", er, rd, rs); end
        run_store(32'h301, 2'b00, 32'h123456AB, be, ad, wd, rs, rd, er, lat);
        total++; if (be !== 4'b0010 || wd !== 32'hABABABAB || ad !== 32'h300)
            begin bad++; $display("FAIL sb got=%b/%h/%h want=0010/abababab/00000300", be, wd, ad); end
        run_store(32'h40C, 2'b10, 32'hCAFEF00D, be, ad, wd, rs, rd, er, lat);
        total++; if (be !== 4'b1111 || wd !== 32'hCAFEF00D || ad !== 32'h40C)
            begin bad++; $display("FAIL sw got=%b/%h/%h want=1111/cafef00d/0000040c", be, wd, ad); end
    endtask

    task automatic test_wait_stall();
        int pulses;
        bif.req_valid = 1; bif.req_write = 1; bif.req_size = 2'b10; bif.req_signed = 0;
        bif.req_addr = 32'h44; bif.req_wdata = 32'h5A5AA5A5; bif.waitrequest = 1;
        @(posedge clk); #1;
        bif.req_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (bif.write !== 1'b1 || bif.read !== 1'b0 || bif.address !== 32'h44 ||
                bif.byteenable !== 4'b1111 || bif.writedata !== 32'h5A5AA5A5 || bif.rsp_valid !== 1'b0)
                begin bad++; $display("FAIL stall_hold_%0d got=w%b r%b %h %b %h v%b want=w1 r0 00000044 1111 5a5aa5a5 v0",
                                      k, bif.write, bif.read, bif.address, bif.byteenable, bif.writedata, bif.rsp_valid); end
        end
        bif.waitrequest = 0;
        @(posedge clk); #1;
        total++; if (bif.write !== 1'b0) begin bad++; $display("FAIL stall_drop got=%b want=0", bif.write); end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bif.rsp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_misaligned();
        logic strobe;
        logic got;
        logic [31:0] rdv;
        logic erv;
        int lat;
        strobe = 1'b0; got = 1'b0; rdv = 32'hFFFFFFFF; erv = 1'b0; lat = -1;
        bif.req_valid = 1; bif.req_write = 0; bif.req_size = 2'b10; bif.req_addr = 32'h101;
        bif.waitrequest = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bif.req_valid = 0;
            if (bif.read || bif.write) strobe = 1'b1;
            if (bif.rsp_valid && !got) begin got = 1'b1; lat = i; rdv = bif.rsp_rdata; erv = bif.rsp_err; end
        end
        total++; if (strobe !== 1'b0) begin bad++; $display("FAIL mis_strobe got=%b want=0", strobe); end
        total++; if (lat !== 1 || erv !== 1'b1 || rdv !== 32'h0)
            begin bad++; $display("FAIL mis_rsp got=lat%0d err%b %h want=lat1 err1 00000000", lat, erv, rdv); end
        strobe = 1'b0; got = 1'b0; erv = 1'b0;
        bif.req_valid = 1; bif.req_write = 1; bif.req_size = 2'b01; bif.req_addr = 32'h0FF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bif.req_valid = 0;
            if (bif.read || bif.write) strobe = 1'b1;
            if (bif.rsp_valid && !got) begin got = 1'b1; erv = bif.rsp_err; end
        end
        total++; if (strobe !== 1'b0 || erv !== 1'b1)
            begin bad++; $display("FAIL mis_half got=strobe%b err%b want=strobe0 err1", strobe, erv); end
    endtask

    task automatic test_watchdog();
        wif.req_valid = 1; wif.req_write = 0; wif.req_size = 2'b10; wif.req_addr = 32'h80;
        wif.waitrequest = 1; wif.readdata = 32'h55555555;
        @(posedge clk); #1;
        wif.req_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (wif.read !== 1'b1) begin bad++; $display("FAIL wd_hold got=%b want=1", wif.read); end
        @(posedge clk); #1;
        total++; if (wif.read !== 1'b0 || wif.rsp_valid !== 1'b0)
            begin bad++; $display("FAIL wd_abort got=r%b v%b want=r0 v0", wif.read, wif.rsp_valid); end
        @(posedge clk); #1;
        total++; if (wif.rsp_valid !== 1'b1 || wif.rsp_err !== 1'b1 || wif.rsp_rdata !== 32'h0)
            begin bad++; $display("FAIL wd_rsp got=v%b e%b %h want=v1 e1 00000000", wif.rsp_valid, wif.rsp_err, wif.rsp_rdata); end
        wif.waitrequest = 0;
    endtask

    task automatic test_reset_mid();
        int pulses;
        bif.req_valid = 1; bif.req_write = 0; bif.req_size = 2'b10; bif.req_addr = 32'h60;
        bif.waitrequest = 1;
        @(posedge clk); #1;
        bif.req_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (bif.read !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b want=1", bif.read); end
        reset = 1;
        @(posedge clk); #1;
        total++; if (bif.read !== 1'b0 || bif.write !== 1'b0 || bif.rsp_valid !== 1'b0)
            begin bad++; $display("FAIL rst_mid_drop got=r%b w%b v%b want=r0 w0 v0", bif.read, bif.write, bif.rsp_valid); end
        reset = 0; bif.waitrequest = 0;
        @(posedge clk); #1;
        total++; if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", bif.req_ready); end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (bif.rsp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_rsp got=%0d want=0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ad; logic er; int lat; logic [3:0] be;
        run_load(32'h500, 2'b00, 1'b0, 32'hA1B2C3D4, rd, er, lat, be, ad);
        total++; if (rd !== 32'h000000D4 || lat !== 3)
            begin bad++; $display("FAIL b2b_first got=%h lat%0d want=000000d4 lat3", rd, lat); end
        run_load(32'h502, 2'b01, 1'b1, 32'h7FFF0000, rd, er, lat, be, ad);
        total++; if (rd !== 32'h00007FFF || lat !== 3)
            begin bad++; $display("FAIL b2b_second got=%h lat%0d want=00007fff lat3", rd, lat); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_word();
        test_subword_loads();
        test_stores();
        test_wait_stall();
        test_misaligned();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
